// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL lock sequencer and its window counter.
package pll_ctrl_pkg;

  localparam int unsigned CNT_W        = 16;
  localparam int unsigned LOCK_CONFIRM = 3;
  localparam int unsigned STATE_W      = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_PRST    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_LOCKED  = 3'd4,
    ST_FAIL    = 3'd5
  } pll_state_e;

  typedef struct packed {
    logic             good;
    logic [CNT_W-1:0] cnt;
  } win_result_t;

endpackage

// File: rtl/pll_win_counter.sv
// Fixed-length measurement window with a saturating fb_tick counter; done_c,
// cnt_c and good_c describe the window that finishes on the current cycle.
module pll_win_counter
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned WIN_CYCLES = 1024,
  parameter int unsigned EXP_CNT    = 64,
  parameter int unsigned TOL        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             fb_tick,
  output logic             done_c,
  output logic [CNT_W-1:0] cnt_c,
  output logic             good_c
);

  localparam int unsigned TMR_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;

  logic [TMR_W-1:0]        r_tmr;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W:0]          w_sum;
  logic signed [CNT_W:0]   w_diff;
  logic [CNT_W:0]          w_mag;

  // A tick on the last window cycle is folded into that window's result.
  assign w_sum  = {1'b0, r_cnt} + (CNT_W+1)'(fb_tick);
  assign cnt_c  = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
  assign done_c = run && (r_tmr == TMR_W'(WIN_CYCLES - 1));

  assign w_diff = $signed({1'b0, cnt_c}) - $signed((CNT_W+1)'(EXP_CNT));
  assign w_mag  = w_diff[CNT_W] ? (CNT_W+1)'(-w_diff) : (CNT_W+1)'(w_diff);
  assign good_c = (w_mag <= (CNT_W+1)'(TOL));

  always_ff @(posedge clk) begin
    if (rst || !run || done_c) begin
      r_tmr <= '0;
      r_cnt <= '0;
    end else begin
      r_tmr <= r_tmr + TMR_W'(1);
      r_cnt <= cnt_c;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Bring-up and lock supervision for the analog PLL macro.
// PLL_LOCK_HYST_EN: require LOCK_CONFIRM consecutive good windows before locking.
module pll_lock_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 8,
  parameter int unsigned SETTLE_CYCLES = 256,
  parameter int unsigned WIN_CYCLES    = 1024,
  parameter int unsigned EXP_CNT       = 64,
  parameter int unsigned TOL           = 2,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned LOSS_MAX      = 2,
  parameter int unsigned DIV_W         = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DIV_W-1:0]   div_cfg,
  input  logic               fb_tick,
  output logic               pll_en,
  output logic               pll_rst,
  output logic [DIV_W-1:0]   div_out,
  output logic               locked,
  output logic               fail,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   last_cnt
);

  localparam int unsigned PH_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int unsigned RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned LOSS_W = (LOSS_MAX > 0) ? $clog2(LOSS_MAX + 1) : 1;

  pll_state_e        r_state, w_state_nxt;
  logic [PH_W-1:0]   r_tmr, w_tmr_nxt;
  logic [RTY_W-1:0]  r_retry, w_retry_nxt;
  logic [LOSS_W-1:0] r_loss, w_loss_nxt;
  logic [DIV_W-1:0]  r_div, w_div_nxt;
  logic              r_locked, w_locked_nxt;
  logic              r_fail, w_fail_nxt;
  logic [CNT_W-1:0]  r_last, w_last_nxt;
  logic              r_pll_en, w_pll_en_nxt;
  logic              r_pll_rst, w_pll_rst_nxt;
  logic              w_run, w_done;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_good;
  win_result_t       w_res;
`ifdef PLL_LOCK_HYST_EN
  localparam int unsigned CONF_W = (LOCK_CONFIRM > 1) ? $clog2(LOCK_CONFIRM) : 1;
  logic [CONF_W-1:0] r_conf, w_conf_nxt;
`endif

  assign w_run = (r_state == ST_MEASURE) || (r_state == ST_LOCKED);
  assign w_res = '{good: w_good, cnt: w_cnt};

  pll_win_counter #(
    .WIN_CYCLES (WIN_CYCLES),
    .EXP_CNT    (EXP_CNT),
    .TOL        (TOL)
  ) u_win (
    .clk     (clk),
    .rst     (rst),
    .run     (w_run),
    .fb_tick (fb_tick),
    .done_c  (w_done),
    .cnt_c   (w_cnt),
    .good_c  (w_good)
  );

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_tmr_nxt    = r_tmr;
    w_retry_nxt  = r_retry;
    w_loss_nxt   = r_loss;
    w_div_nxt    = r_div;
    w_locked_nxt = r_locked;
    w_fail_nxt   = r_fail;
    w_last_nxt   = r_last;
`ifdef PLL_LOCK_HYST_EN
    w_conf_nxt   = r_conf;
`endif
    if (stop) begin
      w_state_nxt  = ST_IDLE;
      w_tmr_nxt    = '0;
      w_retry_nxt  = '0;
      w_loss_nxt   = '0;
      w_locked_nxt = 1'b0;
      w_fail_nxt   = 1'b0;
`ifdef PLL_LOCK_HYST_EN
      w_conf_nxt   = '0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_div_nxt   = div_cfg;
            w_retry_nxt = '0;
            w_tmr_nxt   = '0;
            w_state_nxt = ST_PRST;
          end
        end
        ST_PRST: begin
          if (r_tmr == PH_W'(RST_CYCLES - 1)) begin
            w_tmr_nxt   = '0;
            w_state_nxt = ST_SETTLE;
          end else begin
            w_tmr_nxt = r_tmr + PH_W'(1);
          end
        end
        ST_SETTLE: begin
          if (r_tmr == PH_W'(SETTLE_CYCLES - 1)) begin
            w_tmr_nxt   = '0;
            w_state_nxt = ST_MEASURE;
          end else begin
            w_tmr_nxt = r_tmr + PH_W'(1);
          end
        end
        ST_MEASURE: begin
          if (w_done) begin
            w_last_nxt = w_res.cnt;
            if (w_res.good) begin
`ifdef PLL_LOCK_HYST_EN
              if (r_conf == CONF_W'(LOCK_CONFIRM - 1)) begin
                w_conf_nxt   = '0;
                w_state_nxt  = ST_LOCKED;
                w_locked_nxt = 1'b1;
                w_retry_nxt  = '0;
                w_loss_nxt   = '0;
              end else begin
                w_conf_nxt = r_conf + CONF_W'(1);
              end
`else
              w_state_nxt  = ST_LOCKED;
              w_locked_nxt = 1'b1;
              w_retry_nxt  = '0;
              w_loss_nxt   = '0;
`endif
            end else begin
`ifdef PLL_LOCK_HYST_EN
              w_conf_nxt = '0;
`endif
              if (r_retry == RTY_W'(MAX_RETRY)) begin
                w_state_nxt = ST_FAIL;
                w_fail_nxt  = 1'b1;
              end else begin
                w_retry_nxt = r_retry + RTY_W'(1);
                w_tmr_nxt   = '0;
                w_state_nxt = ST_PRST;
              end
            end
          end
        end
        ST_LOCKED: begin
          if (w_done) begin
            w_last_nxt = w_res.cnt;
            if (w_res.good) begin
              w_loss_nxt = '0;
            end else if (r_loss == LOSS_W'(LOSS_MAX - 1)) begin
              w_loss_nxt   = '0;
              w_retry_nxt  = '0;
              w_locked_nxt = 1'b0;
              w_tmr_nxt    = '0;
              w_state_nxt  = ST_PRST;
            end else begin
              w_loss_nxt = r_loss + LOSS_W'(1);
            end
          end
        end
        ST_FAIL: begin
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
    w_pll_en_nxt  = (w_state_nxt == ST_PRST) || (w_state_nxt == ST_SETTLE) ||
                    (w_state_nxt == ST_MEASURE) || (w_state_nxt == ST_LOCKED);
    w_pll_rst_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_PRST) ||
                    (w_state_nxt == ST_FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_tmr     <= '0;
      r_retry   <= '0;
      r_loss    <= '0;
      r_div     <= '0;
      r_locked  <= 1'b0;
      r_fail    <= 1'b0;
      r_last    <= '0;
      r_pll_en  <= 1'b0;
      r_pll_rst <= 1'b1;
`ifdef PLL_LOCK_HYST_EN
      r_conf    <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_tmr     <= w_tmr_nxt;
      r_retry   <= w_retry_nxt;
      r_loss    <= w_loss_nxt;
      r_div     <= w_div_nxt;
      r_locked  <= w_locked_nxt;
      r_fail    <= w_fail_nxt;
      r_last    <= w_last_nxt;
      r_pll_en  <= w_pll_en_nxt;
      r_pll_rst <= w_pll_rst_nxt;
`ifdef PLL_LOCK_HYST_EN
      r_conf    <= w_conf_nxt;
`endif
    end
  end

  assign pll_en   = r_pll_en;
  assign pll_rst  = r_pll_rst;
  assign div_out  = r_div;
  assign locked   = r_locked;
  assign fail     = r_fail;
  assign state    = r_state;
  assign last_cnt = r_last;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with a cycle-level behavioural model.
module tb_pll_lock_sequencer;

  localparam int P_RST    = 4;
  localparam int P_SETTLE = 16;
  localparam int P_WIN    = 64;
  localparam int P_EXP    = 16;
  localparam int P_TOL    = 1;
  localparam int P_MAXR   = 2;
  localparam int P_LOSS   = 2;
`ifdef PLL_LOCK_HYST_EN
  localparam int LOCK_WIN = 3;
`else
  localparam int LOCK_WIN = 1;
`endif
  localparam int LOCK_EDGE = P_RST + P_SETTLE + P_WIN * LOCK_WIN;

  logic        clk = 1'b0;
  logic        rst, start, stop, fb_tick;
  logic [5:0]  div_cfg;
  logic        pll_en, pll_rst, locked, fail;
  logic [5:0]  div_out;
  logic [2:0]  state;
  logic [15:0] last_cnt;

  logic        sat_rst, sat_start;
  logic        sat_en, sat_prst, sat_locked, sat_fail;
  logic [5:0]  sat_div;
  logic [2:0]  sat_state;
  logic [15:0] sat_last;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int tick_mode = 0;
  int n_per = 0;
  int gcyc = 0;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .RST_CYCLES(P_RST), .SETTLE_CYCLES(P_SETTLE), .WIN_CYCLES(P_WIN), .EXP_CNT(P_EXP),
    .TOL(P_TOL), .MAX_RETRY(P_MAXR), .LOSS_MAX(P_LOSS), .DIV_W(6)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .div_cfg(div_cfg), .fb_tick(fb_tick),
    .pll_en(pll_en), .pll_rst(pll_rst), .div_out(div_out), .locked(locked), .fail(fail),
    .state(state), .last_cnt(last_cnt)
  );

  pll_lock_sequencer #(
    .RST_CYCLES(P_RST), .SETTLE_CYCLES(P_SETTLE), .WIN_CYCLES(70000), .EXP_CNT(P_EXP),
    .TOL(P_TOL), .MAX_RETRY(P_MAXR), .LOSS_MAX(P_LOSS), .DIV_W(6)
  ) u_sat (
    .clk(clk), .rst(sat_rst), .start(sat_start), .stop(1'b0), .div_cfg(6'd3), .fb_tick(1'b1),
    .pll_en(sat_en), .pll_rst(sat_prst), .div_out(sat_div), .locked(sat_locked), .fail(sat_fail),
    .state(sat_state), .last_cnt(sat_last)
  );

  function automatic void chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: phase + elapsed cycles, window tick tally, retry/loss/confirm tallies.
  int m_st = 0, m_el = 0, m_ticks = 0, m_retry = 0, m_loss = 0, m_conf = 0, m_last = 0, m_div = 0;
  bit m_locked = 1'b0, m_fail = 1'b0;

  always @(posedge clk) begin
    int d;
    bit good;
    if (rst) begin
      m_st = 0; m_el = 0; m_ticks = 0; m_retry = 0; m_loss = 0; m_conf = 0;
      m_last = 0; m_div = 0; m_locked = 1'b0; m_fail = 1'b0;
    end else if (stop) begin
      m_st = 0; m_el = 0; m_ticks = 0; m_retry = 0; m_loss = 0; m_conf = 0;
      m_locked = 1'b0; m_fail = 1'b0;
    end else begin
      case (m_st)
        0: if (start) begin m_div = int'(div_cfg); m_retry = 0; m_el = 0; m_st = 1; end
        1: begin m_el++; if (m_el == P_RST) begin m_el = 0; m_st = 2; end end
        2: begin m_el++; if (m_el == P_SETTLE) begin m_el = 0; m_ticks = 0; m_st = 3; end end
        3, 4: begin
          if (fb_tick && m_ticks < 65535) m_ticks++;
          m_el++;
          if (m_el == P_WIN) begin
            m_last = m_ticks;
            d = m_ticks - P_EXP;
            good = ((d < 0) ? -d : d) <= P_TOL;
            m_el = 0; m_ticks = 0;
            if (m_st == 3) begin
              if (good) begin
                m_conf++;
                if (m_conf >= LOCK_WIN) begin
                  m_st = 4; m_locked = 1'b1; m_retry = 0; m_loss = 0; m_conf = 0;
                end
              end else begin
                m_conf = 0;
                if (m_retry < P_MAXR) begin m_retry++; m_st = 1; end
                else begin m_st = 5; m_fail = 1'b1; end
              end
            end else if (good) begin
              m_loss = 0;
            end else begin
              m_loss++;
              if (m_loss >= P_LOSS) begin m_locked = 1'b0; m_st = 1; m_retry = 0; m_loss = 0; end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", int'(state), m_st);
      chk("pll_en", int'(pll_en), int'(m_st >= 1 && m_st <= 4));
      chk("pll_rst", int'(pll_rst), int'(m_st == 0 || m_st == 1 || m_st == 5));
      chk("div_out", int'(div_out), m_div);
      chk("locked", int'(locked), int'(m_locked));
      chk("fail", int'(fail), int'(m_fail));
      chk("last_cnt", int'(last_cnt), m_last);
    end
  end

  // fb_tick source: free-running every 4 cycles, or n_per ticks spread at the start of each window.
  always @(negedge clk) begin
    gcyc++;
    case (tick_mode)
      1: fb_tick = (gcyc % 4 == 0);
      2: fb_tick = (m_st == 3 || m_st == 4) && (m_el % 2 == 0) && (m_el / 2 < n_per);
      default: fb_tick = 1'b0;
    endcase
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic go(input logic [5:0] d);
    div_cfg = d; stop = 1'b0; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; div_cfg = '0; fb_tick = 1'b0;
    sat_rst = 1'b1; sat_start = 1'b0;
    step(1);
    chk_en = 1'b1;
    step(1);
    chk("rst_state", int'(state), 0);
    chk("rst_pll_rst", int'(pll_rst), 1);
    chk("rst_pll_en", int'(pll_en), 0);
    chk("rst_last", int'(last_cnt), 0);
    rst = 1'b0; sat_rst = 1'b0; sat_start = 1'b1;

    // Nominal lock with a tick every 4 cycles.
    tick_mode = 1;
    go(6'd20);
    chk("nom_prst_state", int'(state), 1);
    chk("nom_prst_en", int'(pll_en), 1);
    div_cfg = 6'd7;
    step(3);
    chk("nom_prst_last", int'(pll_rst), 1);
    step(1);
    chk("nom_settle_rst", int'(pll_rst), 0);
    step(LOCK_EDGE - 5);
    chk("nom_prelock", int'(locked), 0);
    step(1);
    chk("nom_locked", int'(locked), 1);
    chk("nom_last", int'(last_cnt), 16);
    chk("nom_div", int'(div_out), 20);
    stop = 1'b1; start = 1'b1;
    step(1);
    chk("stop_start_idle", int'(state), 0);
    chk("stop_unlock", int'(locked), 0);
    stop = 1'b0; start = 1'b0;

    // Tolerance edges in LOCKED, then loss of lock.
    tick_mode = 2; n_per = 15;
    go(6'd5);
    step(LOCK_EDGE);
    chk("tol15_locked", int'(locked), 1);
    chk("tol15_last", int'(last_cnt), 15);
    n_per = 17; step(P_WIN);
    chk("tol17_locked", int'(locked), 1);
    chk("tol17_last", int'(last_cnt), 17);
    n_per = 14; step(P_WIN);
    chk("one_bad_locked", int'(locked), 1);
    chk("one_bad_last", int'(last_cnt), 14);
    n_per = 16; step(P_WIN);
    chk("bad_good_locked", int'(locked), 1);
    n_per = 8; step(P_WIN);
    chk("loss1_locked", int'(locked), 1);
    step(P_WIN);
    chk("loss2_locked", int'(locked), 0);
    chk("loss2_state", int'(state), 1);
    chk("loss2_last", int'(last_cnt), 8);

    // Synchronous reset mid-MEASURE.
    step(30);
    chk("pre_rst_state", int'(state), 3);
    rst = 1'b1;
    step(1);
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_div", int'(div_out), 0);
    chk("mid_rst_last", int'(last_cnt), 0);
    chk("mid_rst_pll_rst", int'(pll_rst), 1);
    rst = 1'b0;

    // 14 ticks from MEASURE is a bad window.
    n_per = 14;
    go(6'd9);
    step(P_RST + P_SETTLE + P_WIN);
    chk("tol14_state", int'(state), 1);
    chk("tol14_locked", int'(locked), 0);
    chk("tol14_last", int'(last_cnt), 14);
    do_stop();

    // No ticks: three windows then FAIL.
    tick_mode = 0;
    go(6'd11);
    step(3 * (P_RST + P_SETTLE + P_WIN) - 1);
    chk("prefail_state", int'(state), 3);
    step(1);
    chk("fail_flag", int'(fail), 1);
    chk("fail_state", int'(state), 5);
    chk("fail_pll_en", int'(pll_en), 0);
    do_stop();
    chk("fail_clr", int'(fail), 0);
    chk("fail_idle", int'(state), 0);

    // Stop during SETTLE.
    tick_mode = 1;
    go(6'd2);
    step(10);
    chk("settle_state", int'(state), 2);
    do_stop();
    chk("stop_settle_state", int'(state), 0);
    chk("stop_settle_rst", int'(pll_rst), 1);

    // Saturation: 70000 cycles of continuous ticks.
    chk("sat_measuring", int'(sat_state), 3);
    for (int i = 0; i < 75000 && sat_last == 16'd0; i++) step(1);
    chk("sat_last", int'(sat_last), 65535);
    chk("sat_retry_state", int'(sat_state), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Digital bring-up and lock-supervision controller for the on-chip analog PLL macro.
- Drives the PLL enable and reset lines and latches the feedback-divider setting.
- Checks lock by counting pre-synchronized feedback-divider pulses over a fixed window of the reference clock.
- Retries on failure and monitors for loss of lock. Sits between the tile I/O pins and the PLL analog block.

Parameters:
- RST_CYCLES, 8: cycles the PLL reset is held asserted.
- SETTLE_CYCLES, 256: cycles waited after reset release before the first measurement.
- WIN_CYCLES, 1024: measurement window length in clk cycles.
- EXP_CNT, 64: expected fb_tick count per window when locked.
- TOL, 2: allowed |count - EXP_CNT| for a good window.
- MAX_RETRY, 3: bad measure windows tolerated before FAIL.
- LOSS_MAX, 2: consecutive bad windows in LOCKED that declare loss of lock.
- DIV_W, 6: divider config width.

Ports:
- clk  in  1  Reference clock; single clock domain.
- rst  in  1  Synchronous, active-high reset.
- start  in  1  Level; leaves IDLE when high.
- stop  in  1  Level; forces IDLE from any state (priority below rst).
- div_cfg  in  DIV_W  Requested feedback divider.
- fb_tick  in  1  One-cycle pulse per feedback wrap, already synchronized to clk.
- pll_en  out  1  PLL enable.
- pll_rst  out  1  PLL reset, active high.
- div_out  out  DIV_W  Latched divider applied to the PLL.
- locked  out  1  Lock status.
- fail  out  1  Sticky lock failure.
- state  out  3  Current FSM state code.
- last_cnt  out  16  fb_tick count of the most recently completed window.

Behaviour:
- Reset values: pll_en=0, pll_rst=1, div_out=0, locked=0, fail=0, state=IDLE(0), last_cnt=0. All counters are cleared.
- rst applied mid-operation returns everything to reset values on the next edge.
- States: IDLE=0, PRST=1, SETTLE=2, MEASURE=3, LOCKED=4, FAIL=5.
- IDLE
  - pll_en=0, pll_rst=1.
  - If start=1 and stop=0: latch div_cfg into div_out, clear retry counter, go to PRST.
- PRST
  - pll_en=1, pll_rst=1 for exactly RST_CYCLES cycles, then go to SETTLE.
- SETTLE
  - pll_rst=0 for SETTLE_CYCLES cycles, then go to MEASURE.
- MEASURE
  - Timer runs for WIN_CYCLES cycles and counts fb_tick. The count saturates at 16'hFFFF.
  - A pulse on the final window cycle is included in that window.
  - At window end, last_cnt is updated and the window is good if |cnt-EXP_CNT| <= TOL.
  - Good window: go to LOCKED, locked=1 on the same edge, clear retry and loss counters.
  - Bad window with retry < MAX_RETRY: increment retry, go to PRST.
  - Bad window with retry == MAX_RETRY: go to FAIL.
- LOCKED
  - Windows run back-to-back with no gap; the counter restarts on the cycle after a window end.
  - Good window clears the loss counter.
  - Bad window increments the loss counter. When it reaches LOSS_MAX, locked=0 on that edge and the FSM goes to PRST with the retry counter cleared.
- FAIL
  - pll_en=0, pll_rst=1, fail=1.
  - Exits only via stop or rst.
  - fail is cleared on entering IDLE.
- stop: from any state, go to IDLE next edge; locked=0 and counters are cleared.
- stop and start both high: stop wins and the FSM stays in IDLE.
- div_cfg changes outside IDLE are ignored.
- Windows are compared as unsigned values with a 17-bit signed difference, so there is no wrap.

Optional Feature:
- Macro: PLL_LOCK_HYST_EN.
- Defined:
  - From MEASURE, a good window advances an internal confirm counter and the FSM stays in MEASURE without a retry.
  - locked asserts only after 3 consecutive good windows.
  - A bad window clears the confirm counter and follows the bad-window rules.
- Undefined: one good window locks. The confirm counter does not exist.

Decomposition:
- Package pll_ctrl_pkg:
  - State enum (3-bit codes above).
  - Count width constant CNT_W=16.
  - LOCK_CONFIRM=3.
  - Typedef for the window result (good, cnt).
- Sub-module pll_win_counter:
  - Window timer plus saturating fb_tick counter.
  - Inputs: clk, rst, run.
  - Outputs: done pulse, cnt, good.
  - Parameters: WIN_CYCLES, EXP_CNT, TOL.

Test Plan:
All scenarios use RST_CYCLES=4, SETTLE_CYCLES=16, WIN_CYCLES=64, EXP_CNT=16, TOL=1, MAX_RETRY=2, LOSS_MAX=2, macro undefined.
- Nominal lock: start=1, div_cfg=6'd20, fb_tick every 4 cycles → pll_rst high 4 cycles; first window ends at cycle 84 after start; locked=1; last_cnt=16; div_out=20.
- Tolerance edges: 15 ticks/window → locked; 17 → locked; 14 → bad window.
- Retry to fail: fb_tick held 0 → three MEASURE windows (two retries through PRST), then fail=1, state=5, pll_en=0; stop → IDLE, fail=0.
- Loss of lock: after lock, two consecutive windows with 8 ticks → locked drops on the second window end, state=1. One bad window followed by a good one → stays locked.
- Async events: stop asserted mid-SETTLE → IDLE next cycle with pll_rst=1; rst asserted mid-MEASURE → all outputs at reset values next edge.
- Saturation and macro: fb_tick held high for a 70000-cycle window → last_cnt=16'hFFFF. With PLL_LOCK_HYST_EN defined, locked asserts after the 3rd good window.
